spectrum_bar_scheduler: RTL

//  Frame scheduler between the spectrum engine and the VGA pixel path. Buffers one

---
 rtl/spectrum_pkg.sv | 17 +
 rtl/bar_bank_ram.sv | 51 +++++
 rtl/spectrum_bar_scheduler.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/spectrum_pkg.sv
// Shared constants and state encoding for the spectrum bar scheduler.
// PEAK_HOLD_EN (optional) enables the peak-hold store in the scheduler and its RAM.
package spectrum_pkg;
    localparam int NUM_BARS   = 40;
    localparam int HEIGHT_W   = 9;
    localparam int BAR_SHIFT  = 4;
    localparam int PEAK_DECAY = 4;
    localparam int X_W        = 10;
    localparam int DROP_W     = 8;
    localparam int IDX_W      = $clog2(NUM_BARS);

    typedef enum logic [1:0] {
        CLEAR = 2'd0,
        FILL  = 2'd1,
        FULL  = 2'd2
    } sched_state_t;
endpackage

// File: rtl/bar_bank_ram.sv
// Two banks of bar heights sharing one write port (per-bank enables) and a registered read.
// With PEAK_HOLD_EN defined, a second registered read port feeds the peak-hold sweep.
module bar_bank_ram #(
    parameter int DEPTH = 40,
    parameter int W     = 9,
    parameter int AW    = 6
) (
    input  logic          clk,
    input  logic [1:0]    we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic          rbank,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
`ifdef PEAK_HOLD_EN
    ,
    input  logic [AW-1:0] saddr,
    output logic [W-1:0]  sdata
`endif
);
    logic rbank_reg;

    always_ff @(posedge clk) begin
        rbank_reg <= rbank;
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : bank_g
            logic [W-1:0] mem [DEPTH];
            logic [W-1:0] q_reg;
`ifdef PEAK_HOLD_EN
            logic [W-1:0] sq_reg;
`endif
            always_ff @(posedge clk) begin
                if (we[gi]) begin
                    mem[waddr] <= wdata;
                end
                q_reg <= mem[raddr];
`ifdef PEAK_HOLD_EN
                sq_reg <= mem[saddr];
`endif
            end
        end
    endgenerate

    assign rdata = rbank_reg ? bank_g[1].q_reg : bank_g[0].q_reg;
`ifdef PEAK_HOLD_EN
    assign sdata = rbank_reg ? bank_g[1].sq_reg : bank_g[0].sq_reg;
`endif
endmodule

// File: rtl/spectrum_bar_scheduler.sv
// Double-buffered frame store of bar heights; banks swap only on a VSync falling edge.
// Optional PEAK_HOLD_EN adds a decaying per-bar peak store swept after each swap.
module spectrum_bar_scheduler
    import spectrum_pkg::*;
(
    input  logic                vclk,
    input  logic                rst,
    input  logic                bin_valid,
    output logic                bin_ready,
    input  logic [IDX_W-1:0]    bin_idx,
    input  logic [HEIGHT_W-1:0] bin_mag,
    input  logic                bin_last,
    input  logic                VSync,
    input  logic [X_W-1:0]      X_PIX,
    output logic [HEIGHT_W-1:0] bar_height,
    output logic [HEIGHT_W-1:0] peak_height,
    output logic                frame_swapped,
    output logic [DROP_W-1:0]   drop_cnt
);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BARS - 1);
    localparam logic [X_W-1:0]   X_LIMIT  = X_W'(NUM_BARS << BAR_SHIFT);

    sched_state_t          state_reg, state_next;
    logic [IDX_W-1:0]      clr_ptr_reg;
    logic                  front_sel_reg;
    logic [DROP_W-1:0]     drop_cnt_reg;
    logic                  frame_swapped_reg;
    logic [1:0]            vs_reg;
    logic                  in_range_reg;

    logic                  vs_edge, xfer, last_xfer, swap, drop, front_next, in_range;
    logic [IDX_W-1:0]      rd_addr;
    logic [1:0]            ram_we;
    logic [IDX_W-1:0]      ram_waddr;
    logic [HEIGHT_W-1:0]   ram_wdata, bank_q;

    // vs_reg[1] is VSync two cycles old, so the edge is seen one cycle after the fall
    assign vs_edge    = vs_reg[1] & ~vs_reg[0];
    assign xfer       = bin_valid & bin_ready;
    assign last_xfer  = xfer & bin_last;
    assign swap       = vs_edge & ((state_reg == FULL) | ((state_reg == FILL) & last_xfer));
    assign drop       = vs_edge & (state_reg == FILL) & ~last_xfer;
    assign front_next = front_sel_reg ^ swap;
    assign in_range   = X_PIX < X_LIMIT;
    assign rd_addr    = in_range ? IDX_W'(X_PIX >> BAR_SHIFT) : '0;

    always_ff @(posedge vclk) begin
        if (rst) begin
            state_reg <= CLEAR;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            CLEAR:   if (clr_ptr_reg == LAST_IDX) state_next = FILL;
            FILL:    if (last_xfer && !vs_edge) state_next = FULL;
            FULL:    if (vs_edge) state_next = FILL;
            default: state_next = CLEAR;
        endcase
    end

    always_comb begin
        bin_ready = (state_reg == FILL);
        ram_we    = 2'b00;
        ram_waddr = bin_idx;
        ram_wdata = bin_mag;
        if (state_reg == CLEAR) begin
            ram_we    = 2'b11;
            ram_waddr = clr_ptr_reg;
            ram_wdata = '0;
        end else if (xfer && (bin_idx <= LAST_IDX)) begin
            ram_we = front_sel_reg ? 2'b01 : 2'b10;
        end
    end

    always_ff @(posedge vclk) begin
        if (rst) begin
            clr_ptr_reg       <= '0;
            front_sel_reg     <= 1'b0;
            drop_cnt_reg      <= '0;
            frame_swapped_reg <= 1'b0;
            vs_reg            <= 2'b11;
            in_range_reg      <= 1'b0;
        end else begin
            if ((state_reg == CLEAR) && (clr_ptr_reg != LAST_IDX)) begin
                clr_ptr_reg <= clr_ptr_reg + IDX_W'(1);
            end
            if (drop && (drop_cnt_reg != '1)) begin
                drop_cnt_reg <= drop_cnt_reg + DROP_W'(1);
            end
            front_sel_reg     <= front_next;
            frame_swapped_reg <= swap;
            vs_reg            <= {vs_reg[0], VSync};
            in_range_reg      <= in_range;
        end
    end

`ifdef PEAK_HOLD_EN
    localparam logic [HEIGHT_W-1:0] DECAY = HEIGHT_W'(PEAK_DECAY);

    logic [HEIGHT_W-1:0] peak_mem [NUM_BARS];
    logic [HEIGHT_W-1:0] peak_q_reg, peak_s_reg, sweep_q, decayed;
    logic [IDX_W-1:0]    sweep_ptr_reg, wb_ptr_reg, peak_waddr;
    logic                sweep_active_reg, wb_valid_reg, peak_we;
    logic [HEIGHT_W-1:0] peak_wdata;

    bar_bank_ram #(.DEPTH(NUM_BARS), .W(HEIGHT_W), .AW(IDX_W)) u_bank (
        .clk(vclk), .we(ram_we), .waddr(ram_waddr), .wdata(ram_wdata),
        .rbank(front_next), .raddr(rd_addr), .rdata(bank_q),
        .saddr(sweep_ptr_reg), .sdata(sweep_q)
    );

    // A swap restarts the sweep; any write-back in flight read the old bank and is dropped
    always_ff @(posedge vclk) begin
        if (rst) begin
            sweep_active_reg <= 1'b0;
            sweep_ptr_reg    <= '0;
            wb_valid_reg     <= 1'b0;
            wb_ptr_reg       <= '0;
        end else if (swap) begin
            sweep_active_reg <= 1'b1;
            sweep_ptr_reg    <= '0;
            wb_valid_reg     <= 1'b0;
        end else begin
            wb_valid_reg <= sweep_active_reg;
            wb_ptr_reg   <= sweep_ptr_reg;
            if (sweep_active_reg) begin
                if (sweep_ptr_reg == LAST_IDX) begin
                    sweep_active_reg <= 1'b0;
                end else begin
                    sweep_ptr_reg <= sweep_ptr_reg + IDX_W'(1);
                end
            end
        end
    end

    always_comb begin
        decayed    = (peak_s_reg > DECAY) ? (peak_s_reg - DECAY) : '0;
        peak_we    = 1'b0;
        peak_waddr = wb_ptr_reg;
        peak_wdata = (sweep_q > decayed) ? sweep_q : decayed;
        if (state_reg == CLEAR) begin
            peak_we    = 1'b1;
            peak_waddr = clr_ptr_reg;
            peak_wdata = '0;
        end else if (wb_valid_reg) begin
            peak_we = 1'b1;
        end
    end

    always_ff @(posedge vclk) begin
        if (peak_we) begin
            peak_mem[peak_waddr] <= peak_wdata;
        end
        peak_q_reg <= peak_mem[rd_addr];
        peak_s_reg <= peak_mem[sweep_ptr_reg];
    end

    assign peak_height = in_range_reg ? peak_q_reg : '0;
`else
    bar_bank_ram #(.DEPTH(NUM_BARS), .W(HEIGHT_W), .AW(IDX_W)) u_bank (
        .clk(vclk), .we(ram_we), .waddr(ram_waddr), .wdata(ram_wdata),
        .rbank(front_next), .raddr(rd_addr), .rdata(bank_q)
    );

    assign peak_height = '0;
`endif

    assign bar_height    = in_range_reg ? bank_q : '0;
    assign frame_swapped = frame_swapped_reg;
    assign drop_cnt      = drop_cnt_reg;
endmodule
